// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word addresses to a registered ROM and
// buffers returning words in a 2-entry FIFO in front of decode.
module fetch_unit #(
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  output logic [29:0] inst_addr,
  input  logic [31:0] inst_in,
  input  logic        redirect,
  input  logic [29:0] redirect_addr,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [29:0] pc_out
);

  logic [29:0] pc;
  logic [29:0] flight_pc;
  logic        flight_v;

  logic [29:0] fifo_pc   [2];
  logic [31:0] fifo_inst [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [1:0]  next_count;

  logic deq;
  logic push;
  logic issue;

  assign inst_addr  = pc;
  assign inst_valid = (count != 2'd0);
  assign inst_out   = fifo_inst[rd_ptr];
  assign pc_out     = fifo_pc[rd_ptr];

  // Issue only when the word now in flight is guaranteed a FIFO slot next cycle.
  always_comb begin
    deq        = clk_en && inst_valid && !stall;
    push       = clk_en && flight_v && !redirect;
    next_count = count + {1'b0, push} - {1'b0, deq};
    issue      = clk_en && !redirect && (next_count < 2'd2);
  end

  // The ROM keeps clocking while disabled, so a request issued last edge is
  // lost and must be re-fetched from flight_pc once enabled again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      flight_v  <= 1'b0;
      flight_pc <= '0;
    end else if (!clk_en) begin
      if (flight_v) begin
        pc       <= flight_pc;
        flight_v <= 1'b0;
      end
    end else if (redirect) begin
      pc       <= redirect_addr;
      flight_v <= 1'b0;
    end else if (issue) begin
      flight_v  <= 1'b1;
      flight_pc <= pc;
      pc        <= pc + 30'd1;
    end else begin
      flight_v <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_pc[0]   <= '0;
      fifo_pc[1]   <= '0;
      fifo_inst[0] <= '0;
      fifo_inst[1] <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= 2'd0;
    end else if (clk_en) begin
      if (redirect) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) begin
          fifo_pc[wr_ptr]   <= flight_pc;
          fifo_inst[wr_ptr] <= inst_in;
          wr_ptr            <= ~wr_ptr;
        end
        if (deq) begin
          rd_ptr <= ~rd_ptr;
        end
        count <= next_count;
      end
    end
  end

endmodule
